// File: rtl/neuronal_pipe_arbiter.sv
// Round-robin arbiter with burst lock sharing one registered pipe stage between NUM_REQ requesters.
// Optional NEURONAL_PIPE_ARB_STATS_EN adds per-requester grant counters and starvation flags.
module neuronal_pipe_arbiter #(
    parameter int unsigned NUM_REQ   = 4,
    parameter int unsigned DATA_W    = 32,
    parameter int unsigned ID_W      = 2,
    parameter int unsigned MAX_BURST = 8,
    parameter int unsigned PIPE_LAT  = 1
) (
    input  logic                      i_clk,
    input  logic                      i_reset,
    input  logic [NUM_REQ-1:0]        i_req_valid,
    input  logic [NUM_REQ-1:0]        i_req_last,
    input  logic [NUM_REQ*DATA_W-1:0] i_req_data,
    output logic [NUM_REQ-1:0]        o_req_ready,
    input  logic                      i_dn_ready,
    output logic [DATA_W-1:0]         o_pipe_in_data,
    input  logic [DATA_W-1:0]         i_pipe_out_data,
    output logic                      o_rsp_valid,
    output logic [ID_W-1:0]           o_rsp_id,
    output logic [DATA_W-1:0]         o_rsp_data,
    output logic                      o_busy
`ifdef NEURONAL_PIPE_ARB_STATS_EN
    ,
    output logic [NUM_REQ*16-1:0]     o_grant_cnt,
    output logic [NUM_REQ-1:0]        o_starve_flag
`endif
);

    typedef enum logic [0:0] {StIdle, StBurst} state_e;

    state_e          r_state, w_state_d;
    logic [ID_W-1:0] r_rr_ptr, w_rr_ptr_d;
    logic [ID_W-1:0] r_owner, w_owner_d;
    logic [7:0]      r_beat_cnt, w_beat_cnt_d;

    logic [PIPE_LAT-1:0] r_tag_vld;
    logic [ID_W-1:0]     r_tag_id [PIPE_LAT];

    logic [2*NUM_REQ-1:0] w_dbl;
    logic [NUM_REQ-1:0]   w_rot;
    logic                 w_found;
    logic [ID_W-1:0]      w_winner;
    logic                 w_accept;
    logic [ID_W-1:0]      w_acc_id;
    logic [DATA_W-1:0]    w_req_data [NUM_REQ];
    int                   w_idx;

    function automatic logic [ID_W-1:0] next_id(input logic [ID_W-1:0] x);
        if (int'(x) == int'(NUM_REQ) - 1) return '0;
        return x + ID_W'(1);
    endfunction

    // Rotate valids so bit 0 is the requester at rr_ptr; first set bit wins.
    always_comb begin
        w_dbl    = {i_req_valid, i_req_valid} >> r_rr_ptr;
        w_rot    = w_dbl[NUM_REQ-1:0];
        w_found  = 1'b0;
        w_winner = '0;
        w_idx    = 0;
        for (int k = 0; k < int'(NUM_REQ); k++) begin
            if (!w_found && w_rot[k]) begin
                w_found = 1'b1;
                w_idx   = int'(r_rr_ptr) + k;
                if (w_idx >= int'(NUM_REQ)) w_idx = w_idx - int'(NUM_REQ);
                w_winner = ID_W'(w_idx);
            end
        end
    end

    always_comb begin
        for (int i = 0; i < int'(NUM_REQ); i++) begin
            w_req_data[i] = i_req_data[i*DATA_W +: DATA_W];
        end
    end

    always_comb begin
        w_state_d    = r_state;
        w_rr_ptr_d   = r_rr_ptr;
        w_owner_d    = r_owner;
        w_beat_cnt_d = r_beat_cnt;
        w_accept     = 1'b0;
        w_acc_id     = '0;
        if (!i_reset && i_dn_ready) begin
            unique case (r_state)
                StIdle: begin
                    if (w_found) begin
                        w_accept = 1'b1;
                        w_acc_id = w_winner;
                        if (i_req_last[w_winner] || MAX_BURST == 1) begin
                            w_rr_ptr_d = next_id(w_winner);
                        end else begin
                            w_state_d    = StBurst;
                            w_owner_d    = w_winner;
                            w_beat_cnt_d = 8'd1;
                        end
                    end
                end
                StBurst: begin
                    if (i_req_valid[r_owner]) begin
                        w_accept = 1'b1;
                        w_acc_id = r_owner;
                        if (i_req_last[r_owner] ||
                            (9'(r_beat_cnt) + 9'd1) == 9'(MAX_BURST)) begin
                            w_state_d    = StIdle;
                            w_rr_ptr_d   = next_id(r_owner);
                            w_beat_cnt_d = '0;
                        end else begin
                            w_beat_cnt_d = r_beat_cnt + 8'd1;
                        end
                    end else begin
                        w_state_d    = StIdle;
                        w_rr_ptr_d   = next_id(r_owner);
                        w_beat_cnt_d = '0;
                    end
                end
                default: w_state_d = StIdle;
            endcase
        end
    end

    always_comb begin
        o_req_ready    = '0;
        o_pipe_in_data = '0;
        if (w_accept) begin
            o_req_ready[w_acc_id] = 1'b1;
            o_pipe_in_data        = w_req_data[w_acc_id];
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_state    <= StIdle;
            r_rr_ptr   <= '0;
            r_owner    <= '0;
            r_beat_cnt <= '0;
        end else begin
            r_state    <= w_state_d;
            r_rr_ptr   <= w_rr_ptr_d;
            r_owner    <= w_owner_d;
            r_beat_cnt <= w_beat_cnt_d;
        end
    end

    // Tag line mirrors the pipe latency so the tail lines up with i_pipe_out_data.
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_tag_vld <= '0;
            for (int i = 0; i < int'(PIPE_LAT); i++) r_tag_id[i] <= '0;
        end else begin
            r_tag_vld[0] <= w_accept;
            r_tag_id[0]  <= w_acc_id;
            for (int i = 1; i < int'(PIPE_LAT); i++) begin
                r_tag_vld[i] <= r_tag_vld[i-1];
                r_tag_id[i]  <= r_tag_id[i-1];
            end
        end
    end

    assign o_rsp_valid = r_tag_vld[PIPE_LAT-1];
    assign o_rsp_id    = r_tag_id[PIPE_LAT-1];
    assign o_rsp_data  = i_pipe_out_data;
    assign o_busy      = (r_state == StBurst) || (|r_tag_vld);

`ifdef NEURONAL_PIPE_ARB_STATS_EN
    localparam int unsigned StarveLimit = NUM_REQ * MAX_BURST;

    logic [15:0]        r_grant_cnt [NUM_REQ];
    logic [15:0]        r_wait_cnt  [NUM_REQ];
    logic [NUM_REQ-1:0] r_starve;

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_starve <= '0;
            for (int i = 0; i < int'(NUM_REQ); i++) begin
                r_grant_cnt[i] <= '0;
                r_wait_cnt[i]  <= '0;
            end
        end else begin
            for (int i = 0; i < int'(NUM_REQ); i++) begin
                if (o_req_ready[i] && r_grant_cnt[i] != 16'hFFFF) begin
                    r_grant_cnt[i] <= r_grant_cnt[i] + 16'd1;
                end
                if (i_req_valid[i] && !o_req_ready[i]) begin
                    if (r_wait_cnt[i] != 16'hFFFF) r_wait_cnt[i] <= r_wait_cnt[i] + 16'd1;
                    if (r_wait_cnt[i] >= 16'(StarveLimit)) r_starve[i] <= 1'b1;
                end else begin
                    r_wait_cnt[i] <= '0;
                end
            end
        end
    end

    always_comb begin
        for (int i = 0; i < int'(NUM_REQ); i++) o_grant_cnt[i*16 +: 16] = r_grant_cnt[i];
    end
    assign o_starve_flag = r_starve;
`endif

endmodule

// File: tb/tb_neuronal_pipe_arbiter.sv
// Bench for neuronal_pipe_arbiter: directed scenarios then random traffic, checked against a
// transaction-level model of the arbitration rules and the response delay line.
module tb_neuronal_pipe_arbiter;

    localparam int unsigned N   = 4;
    localparam int unsigned DW  = 32;
    localparam int unsigned IW  = 2;
    localparam int unsigned MB  = 8;
    localparam int unsigned LAT = 2;

    logic              clk = 1'b0;
    logic              reset;
    logic [N-1:0]      req_valid;
    logic [N-1:0]      req_last;
    logic [N*DW-1:0]   req_data;
    logic [N-1:0]      req_ready;
    logic              dn_ready;
    logic [DW-1:0]     pipe_in_data;
    logic [DW-1:0]     pipe_out_data;
    logic              rsp_valid;
    logic [IW-1:0]     rsp_id;
    logic [DW-1:0]     rsp_data;
    logic              busy;
`ifdef NEURONAL_PIPE_ARB_STATS_EN
    logic [N*16-1:0]   grant_cnt;
    logic [N-1:0]      starve_flag;
`endif

    always #5 clk = ~clk;

    neuronal_pipe_arbiter #(
        .NUM_REQ  (N),
        .DATA_W   (DW),
        .ID_W     (IW),
        .MAX_BURST(MB),
        .PIPE_LAT (LAT)
    ) dut (
        .i_clk          (clk),
        .i_reset        (reset),
        .i_req_valid    (req_valid),
        .i_req_last     (req_last),
        .i_req_data     (req_data),
        .o_req_ready    (req_ready),
        .i_dn_ready     (dn_ready),
        .o_pipe_in_data (pipe_in_data),
        .i_pipe_out_data(pipe_out_data),
        .o_rsp_valid    (rsp_valid),
        .o_rsp_id       (rsp_id),
        .o_rsp_data     (rsp_data),
        .o_busy         (busy)
`ifdef NEURONAL_PIPE_ARB_STATS_EN
        ,
        .o_grant_cnt    (grant_cnt),
        .o_starve_flag  (starve_flag)
`endif
    );

    // The shared pipe stage itself: a plain LAT-cycle delay.
    logic [DW-1:0] pipe_q [LAT];
    always @(posedge clk) begin
        pipe_q[0] <= pipe_in_data;
        for (int i = 1; i < int'(LAT); i++) pipe_q[i] <= pipe_q[i-1];
    end
    assign pipe_out_data = pipe_q[LAT-1];

    // Model: lock_owner = -1 when no burst holds the pipe.
    int            lock_owner;
    int            beats;
    int            rr;
    logic          mq_v  [LAT];
    int            mq_id [LAT];
    logic [DW-1:0] mq_d  [LAT];
    int            errors = 0;
    int            checks = 0;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic reset_model();
        lock_owner = -1;
        beats      = 0;
        rr         = 0;
        for (int i = 0; i < int'(LAT); i++) begin
            mq_v[i]  = 1'b0;
            mq_id[i] = 0;
            mq_d[i]  = '0;
        end
    endtask

    function automatic int pick();
        if (reset || !dn_ready) return -1;
        if (lock_owner >= 0) return req_valid[lock_owner] ? lock_owner : -1;
        for (int k = 0; k < int'(N); k++) begin
            if (req_valid[(rr + k) % N]) return (rr + k) % N;
        end
        return -1;
    endfunction

    task automatic set_in(input logic [N-1:0] v, input logic [N-1:0] l, input logic dn,
                          input logic rst);
        req_valid = v;
        req_last  = l;
        dn_ready  = dn;
        reset     = rst;
        for (int i = 0; i < int'(N); i++) req_data[i*DW +: DW] = $urandom;
    endtask

    task automatic step();
        int            g;
        logic [N-1:0]  exp_rdy;
        logic [DW-1:0] exp_pin;
        logic          exp_busy;
        @(negedge clk);
        g        = pick();
        exp_rdy  = '0;
        exp_pin  = '0;
        if (g >= 0) begin
            exp_rdy[g] = 1'b1;
            exp_pin    = req_data[g*DW +: DW];
        end
        exp_busy = (lock_owner >= 0);
        for (int i = 0; i < int'(LAT); i++) if (mq_v[i]) exp_busy = 1'b1;
        chk("req_ready", 64'(req_ready), 64'(exp_rdy));
        chk("pipe_in_data", 64'(pipe_in_data), 64'(exp_pin));
        chk("rsp_valid", 64'(rsp_valid), 64'(mq_v[LAT-1]));
        chk("rsp_id", 64'(rsp_id), 64'(mq_id[LAT-1]));
        chk("busy", 64'(busy), 64'(exp_busy));
        if (mq_v[LAT-1]) chk("rsp_data", 64'(rsp_data), 64'(mq_d[LAT-1]));

        if (reset) begin
            reset_model();
        end else begin
            for (int i = int'(LAT) - 1; i > 0; i--) begin
                mq_v[i]  = mq_v[i-1];
                mq_id[i] = mq_id[i-1];
                mq_d[i]  = mq_d[i-1];
            end
            mq_v[0]  = (g >= 0);
            mq_id[0] = (g >= 0) ? g : 0;
            mq_d[0]  = exp_pin;
            if (dn_ready) begin
                if (lock_owner >= 0) begin
                    if (g >= 0) begin
                        beats++;
                        if (req_last[g] || beats == int'(MB)) begin
                            lock_owner = -1;
                            beats      = 0;
                            rr         = (g + 1) % N;
                        end
                    end else begin
                        rr         = (lock_owner + 1) % N;
                        lock_owner = -1;
                        beats      = 0;
                    end
                end else if (g >= 0) begin
                    if (req_last[g] || MB == 1) begin
                        rr = (g + 1) % N;
                    end else begin
                        lock_owner = g;
                        beats      = 1;
                    end
                end
            end
        end
        @(posedge clk);
        #1;
    endtask

    initial begin
        set_in('0, '0, 1'b1, 1'b1);
        @(posedge clk);
        #1;
        reset_model();
        step();

        // Single requester, one beat tagged with ID 1.
        set_in(4'b0010, 4'b0010, 1'b1, 1'b0);
        req_data[1*DW +: DW] = 32'hDEADBEEF;
        step();
        set_in('0, '0, 1'b1, 1'b0);
        repeat (3) step();

        // Round robin with single-beat bursts.
        set_in('0, '0, 1'b1, 1'b1);
        step();
        repeat (5) begin
            set_in(4'b1111, 4'b1111, 1'b1, 1'b0);
            step();
        end
        set_in('0, '0, 1'b1, 1'b0);
        repeat (3) step();

        // Burst cap: park rr at 2, then requester 2 bursts against requester 0.
        set_in('0, '0, 1'b1, 1'b1);
        step();
        set_in(4'b0010, 4'b0010, 1'b1, 1'b0);
        step();
        repeat (12) begin
            set_in(4'b0101, 4'b0001, 1'b1, 1'b0);
            step();
        end
        set_in('0, '0, 1'b1, 1'b0);
        repeat (3) step();

        // Lock release: owner 3 drops valid while requester 1 waits.
        set_in('0, '0, 1'b1, 1'b1);
        step();
        repeat (2) begin
            set_in(4'b1000, 4'b0000, 1'b1, 1'b0);
            step();
        end
        repeat (2) begin
            set_in(4'b0010, 4'b0000, 1'b1, 1'b0);
            step();
        end
        set_in('0, '0, 1'b1, 1'b0);
        repeat (3) step();

        // Downstream stall mid-burst.
        set_in('0, '0, 1'b1, 1'b1);
        step();
        repeat (3) begin
            set_in(4'b0001, 4'b0000, 1'b1, 1'b0);
            step();
        end
        repeat (3) begin
            set_in(4'b0001, 4'b0000, 1'b0, 1'b0);
            step();
        end
        repeat (6) begin
            set_in(4'b0001, 4'b0000, 1'b1, 1'b0);
            step();
        end
        set_in('0, '0, 1'b1, 1'b0);
        repeat (3) step();

        // Reset right after an accept drops the in-flight response.
        set_in(4'b0100, 4'b0100, 1'b1, 1'b0);
        step();
        set_in('0, '0, 1'b1, 1'b1);
        step();
        set_in(4'b1010, 4'b1010, 1'b1, 1'b0);
        step();
        set_in('0, '0, 1'b1, 1'b0);
        repeat (3) step();

        repeat (800) begin
            logic [N-1:0] l;
            for (int i = 0; i < int'(N); i++) l[i] = ($urandom_range(0, 2) == 0);
            set_in(N'($urandom), l, ($urandom_range(0, 7) != 0), ($urandom_range(0, 99) == 0));
            step();
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
